// File: rtl/spi_rx_word_assembler.sv
// SPI mode-0 slave receiver: samples sclk/mosi/cs_n in the clk domain
// and assembles MSB-first bits into WORD_W-bit words.
//
// Optional feature macro: SPI_RX_PARITY_EN
//   defined   : each word is followed by one even-parity bit
//               (WORD_W+1 bits per word); a parity mismatch
//               drops the word and pulses frame_err.
//   undefined : words are exactly WORD_W bits, no parity bit.
//
// Ports:
//   clk               system clock
//   reset_b           synchronous active-low reset
//   spi_sclk          SPI clock (async, f(clk) >= 4*f(sclk))
//   spi_mosi          SPI data, taken on sclk rising edge
//   spi_cs_n          SPI chip select, active-low
//   data_in_from_spi  last complete word, held until the next
//   write_en_frm_spi  1-cycle strobe, data_in_from_spi valid
//   rx_busy           frame active (FSM not idle)
//   frame_err         1-cycle strobe: partial word / bad parity
//   word_cnt          words delivered since reset, saturating

module spi_rx_word_assembler #(
   parameter int WORD_W      = 256,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   input  logic              spi_cs_n,
   output logic [WORD_W-1:0] data_in_from_spi,
   output logic              write_en_frm_spi,
   output logic              rx_busy,
   output logic              frame_err,
   output logic [CNT_W-1:0]  word_cnt
);

`ifdef SPI_RX_PARITY_EN
   localparam int FRAME_BITS = WORD_W + 1;
`else
   localparam int FRAME_BITS = WORD_W;
`endif
   localparam int BC_W = $clog2(FRAME_BITS + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      PUBLISH
   } state_t;

   state_t state;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic                   sclk_s_d;

   logic sclk_s;
   logic mosi_s;
   logic cs_s;
   logic rise;

   logic [WORD_W-1:0] shift;
   logic [BC_W-1:0]   bit_cnt;

   logic word_ok;

`ifdef SPI_RX_PARITY_EN
   // par_acc: running XOR of the data bits of the current word
   // par_bit: received parity bit
   logic par_acc;
   logic par_bit;
   logic data_bit;

   // The last bit position of a frame carries parity, not data.
   assign data_bit = (bit_cnt != LAST_BIT);
   assign word_ok  = ~(par_acc ^ par_bit);
`else
   assign word_ok  = 1'b1;
`endif

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign rise   = sclk_s & ~sclk_s_d;

   assign rx_busy = (state != IDLE);

   // mosi travels through the same depth as sclk so the bit is
   // aligned with the detected rising edge.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_sync   <= '0;
         sclk_s_d  <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         sclk_s_d  <= sclk_s;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state            <= IDLE;
         shift            <= '0;
         bit_cnt          <= '0;
         data_in_from_spi <= '0;
         write_en_frm_spi <= 1'b0;
         frame_err        <= 1'b0;
         word_cnt         <= '0;
`ifdef SPI_RX_PARITY_EN
         par_acc          <= 1'b0;
         par_bit          <= 1'b0;
`endif
      end else begin
         write_en_frm_spi <= 1'b0;
         frame_err        <= 1'b0;

         unique case (state)
            IDLE: begin
               if (!cs_s) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
`ifdef SPI_RX_PARITY_EN
                  par_acc <= 1'b0;
`endif
               end
            end

            SHIFT: begin
               if (cs_s) begin
                  // cs_n released: clean only on a word boundary
                  if (bit_cnt != '0) begin
                     frame_err <= 1'b1;
                  end
                  bit_cnt <= '0;
                  state   <= IDLE;
               end else if (rise) begin
`ifdef SPI_RX_PARITY_EN
                  if (data_bit) begin
                     shift   <= {shift[WORD_W-2:0], mosi_s};
                     par_acc <= par_acc ^ mosi_s;
                  end else begin
                     par_bit <= mosi_s;
                  end
`else
                  shift <= {shift[WORD_W-2:0], mosi_s};
`endif
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     state   <= PUBLISH;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            PUBLISH: begin
               if (word_ok) begin
                  data_in_from_spi <= shift;
                  write_en_frm_spi <= 1'b1;
                  if (word_cnt != '1) begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end else begin
                  frame_err <= 1'b1;
               end

               if (cs_s) begin
                  state <= IDLE;
               end else begin
                  state <= SHIFT;
                  // An edge landing here is bit 0 of the next
                  // word; shift reads the old value above, so
                  // the published word is unaffected.
                  if (rise) begin
                     shift   <= {shift[WORD_W-2:0], mosi_s};
                     bit_cnt <= BC_W'(1);
`ifdef SPI_RX_PARITY_EN
                     par_acc <= mosi_s;
`endif
                  end
`ifdef SPI_RX_PARITY_EN
                  else begin
                     par_acc <= 1'b0;
                  end
`endif
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
